// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer and its counter logic.
package branch_predictor_pkg;

  localparam int ENTRIES_DEFAULT = 16;
  localparam int ADDR_W          = 30;  // word address width, pc[31:2]
  localparam int CTR_W           = 2;

  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Two-bit saturating direction counter: next state from current state and outcome.
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, EX and ID updates at the edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic              jump_taken_predict,
  output logic [ADDR_W-1:0] jump_target_predict,
  input  logic              upd_ex_valid,
  input  logic [ADDR_W-1:0] upd_ex_pc,
  input  logic              upd_ex_taken,
  input  logic [ADDR_W-1:0] upd_ex_target,
  input  logic              upd_id_valid,
  input  logic [ADDR_W-1:0] upd_id_pc,
  input  logic [ADDR_W-1:0] upd_id_target
);

  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] uncond_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];

  // Lookup: byte offset bits of the fetch pc carry no information.
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic             unused_pc_bits;

  assign rd_idx         = pc[2 +: IDX_W];
  assign rd_tag         = pc[31 -: TAG_W];
  assign rd_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign unused_pc_bits = ^pc[1:0];

  assign jump_taken_predict  = rd_hit && (uncond_q[rd_idx] || ctr_q[rd_idx][1]);
  assign jump_target_predict = rd_hit ? target_q[rd_idx] : '0;

  logic [IDX_W-1:0] ex_idx, id_idx;
  logic [TAG_W-1:0] ex_tag, id_tag;
  logic             ex_hit, ex_write, id_write;
  ctr_t             ex_ctr_next;

  assign ex_idx = upd_ex_pc[IDX_W-1:0];
  assign ex_tag = upd_ex_pc[ADDR_W-1 -: TAG_W];
  assign id_idx = upd_id_pc[IDX_W-1:0];
  assign id_tag = upd_id_pc[ADDR_W-1 -: TAG_W];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  bp_sat_ctr u_ex_ctr (
    .ctr      (ctr_q[ex_idx]),
    .taken    (upd_ex_taken),
    .ctr_next (ex_ctr_next)
  );

  // A not-taken miss leaves the table alone; the resolved branch wins an index collision.
  assign ex_write = upd_ex_valid && (ex_hit || upd_ex_taken);
  assign id_write = upd_id_valid && !(upd_ex_valid && (id_idx == ex_idx));

  // NOTE: only the valid bits are reset; payload arrays stay reset-free since valid gates every read.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (id_write) begin
        valid_q[id_idx]  <= 1'b1;
        uncond_q[id_idx] <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= upd_id_target;
        ctr_q[id_idx]    <= CTR_ST;
      end
      if (ex_write) begin
        valid_q[ex_idx]  <= 1'b1;
        uncond_q[ex_idx] <= 1'b0;
        tag_q[ex_idx]    <= ex_tag;
        ctr_q[ex_idx]    <= ex_hit ? ex_ctr_next : CTR_WT;
        if (upd_ex_taken) target_q[ex_idx] <= upd_ex_target;
      end
    end
  end

endmodule
